// File: rtl/transmitter_if.sv
// Host-side word handshake and coax line outputs of the 3270 transmitter.
interface transmitter_if;
  logic [11:0] txWord;
  logic        txValid;
  logic        txReady;
  logic        serialOut;
  logic        txActive;

  modport master (output txWord, txValid, input txReady, serialOut, txActive);
  modport slave  (input txWord, txValid, output txReady, serialOut, txActive);
endinterface

// File: rtl/transmitter.sv
// 3270 coax transmitter: header, Manchester-coded 12-bit words, violation trailer, idle gap.
// state   | meaning
// IDLE    | line low, waiting for a queued word
// HEADER  | sending the 16 header half-bits
// WORD    | sending 24 half-bits of the shifter, chaining queued words
// TRAILER | sending the code-violation trailer
// GAP     | enforced idle-low time before the next header
module transmitter #(
  parameter int          HALF_BIT   = 20,
  parameter logic [15:0] HEADER     = 16'b0101010101000111,
  parameter logic [5:0]  TRAILER    = 6'b111000,
  parameter int          GAP_HALVES = 8
) (
  input  logic         clk,
  input  logic         reset,
  transmitter_if.slave tx
);
  localparam int CNT_W   = (HALF_BIT > 1) ? $clog2(HALF_BIT) : 1;
  localparam int IDX_MAX = (GAP_HALVES > 24) ? GAP_HALVES : 24;
  localparam int IDX_W   = $clog2(IDX_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_BIT - 1);

  typedef enum logic [2:0] {S_IDLE, S_HEADER, S_WORD, S_TRAILER, S_GAP} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d, idx_dec;
  logic [11:0]      hold_q, hold_d;
  logic [11:0]      shift_q, shift_d;
  logic             hold_full_q, hold_full_d;
  logic             ready_q, ready_d;
  logic             serial_q, serial_d;
  logic             active_q, active_d;
  logic             transfer, cell_end, last_cell, drain;

  always_comb begin
    transfer    = tx.txValid && ready_q;
    cell_end    = (cnt_q == '0);
    last_cell   = (idx_q == '0);
    idx_dec     = idx_q - IDX_W'(1);
    state_d     = state_q;
    cnt_d       = cell_end ? CNT_LAST : cnt_q - CNT_W'(1);
    idx_d       = idx_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    serial_d    = serial_q;
    active_d    = active_q;
    drain       = 1'b0;

    if (transfer) begin
      hold_d      = tx.txWord;
      hold_full_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        serial_d = 1'b0;
        active_d = 1'b0;
        cnt_d    = CNT_LAST;
        if (hold_full_q) begin
          state_d  = S_HEADER;
          idx_d    = IDX_W'(15);
          serial_d = HEADER[15];
          active_d = 1'b1;
        end
      end
      S_HEADER: begin
        if (cell_end) begin
          if (last_cell) begin
            state_d     = S_WORD;
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            drain       = 1'b1;
            idx_d       = IDX_W'(23);
            serial_d    = ~hold_q[11];
          end else begin
            idx_d    = idx_dec;
            serial_d = HEADER[idx_dec[3:0]];
          end
        end
      end
      S_WORD: begin
        if (cell_end) begin
          if (last_cell) begin
            if (hold_full_q) begin
              shift_d     = hold_q;
              hold_full_d = 1'b0;
              drain       = 1'b1;
              idx_d       = IDX_W'(23);
              serial_d    = ~hold_q[11];
            end else if (transfer) begin
              // A word arriving exactly on the boundary bypasses the holding register.
              shift_d     = tx.txWord;
              hold_full_d = 1'b0;
              idx_d       = IDX_W'(23);
              serial_d    = ~tx.txWord[11];
            end else begin
              state_d  = S_TRAILER;
              idx_d    = IDX_W'(5);
              serial_d = TRAILER[5];
            end
          end else begin
            idx_d = idx_dec;
            if (idx_q[0]) begin
              serial_d = shift_q[11];
            end else begin
              shift_d  = {shift_q[10:0], 1'b0};
              serial_d = ~shift_q[10];
            end
          end
        end
      end
      S_TRAILER: begin
        if (cell_end) begin
          if (last_cell) begin
            state_d  = S_GAP;
            idx_d    = IDX_W'(GAP_HALVES - 1);
            serial_d = 1'b0;
            active_d = 1'b0;
          end else begin
            idx_d    = idx_dec;
            serial_d = TRAILER[idx_dec[2:0]];
          end
        end
      end
      S_GAP: begin
        serial_d = 1'b0;
        active_d = 1'b0;
        if (cell_end) begin
          if (last_cell) state_d = S_IDLE;
          else           idx_d   = idx_dec;
        end
      end
      default: begin
        state_d  = S_IDLE;
        serial_d = 1'b0;
        active_d = 1'b0;
      end
    endcase

    // Ready reopens one edge after the holding register drains into the shifter.
    ready_d = ~hold_full_d & ~drain;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      hold_q      <= '0;
      shift_q     <= '0;
      hold_full_q <= 1'b0;
      ready_q     <= 1'b0;
      serial_q    <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      hold_q      <= hold_d;
      shift_q     <= shift_d;
      hold_full_q <= hold_full_d;
      ready_q     <= ready_d;
      serial_q    <= serial_d;
      active_q    <= active_d;
    end
  end

  assign tx.txReady   = ready_q;
  assign tx.serialOut = serial_q;
  assign tx.txActive  = active_q;
endmodule

// File: tb/tb_transmitter.sv
// Bench for transmitter: three instances (HALF_BIT 20, 17, 25) with a behavioural line decoder and word scoreboard.
module tb_transmitter;
  localparam logic [15:0] HDR = 16'b0101010101000111;

  function automatic int hb(input int k);
    case (k)
      1:       return 17;
      2:       return 25;
      default: return 20;
    endcase
  endfunction

  logic        clk;
  logic        reset;
  logic [2:0]  valid;
  logic [11:0] word [3];
  wire  [2:0]  ready, ser, act;

  int tests_run = 0;
  int tests_failed = 0;

  logic [13:0] exp_q [$];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    transmitter_if bus ();
    assign bus.txWord  = word[g];
    assign bus.txValid = valid[g];
    assign ready[g]    = bus.txReady;
    assign ser[g]      = bus.serialOut;
    assign act[g]      = bus.txActive;
    transmitter #(.HALF_BIT(hb(g))) u_dut (.clk(clk), .reset(reset), .tx(bus.slave));
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decoder state, one slot per instance
  int          cycle = 0;
  int          cyc [3], nhb [3], nbits [3];
  logic [15:0] hdr [3];
  logic [11:0] wbits [3];
  logic        first [3];
  logic        done [3];
  logic [2:0]  act_p = '0, ser_p = '0;
  int act_len [3]      = '{0, 0, 0};
  int last_act_len [3] = '{0, 0, 0};
  int idle_len [3]     = '{0, 0, 0};
  int last_idle [3]    = '{0, 0, 0};
  int frames [3]       = '{0, 0, 0};
  int trailers [3]     = '{0, 0, 0};
  int aborts [3]       = '{0, 0, 0};
  int wif [3]          = '{0, 0, 0};
  int last_fw [3]      = '{0, 0, 0};
  int delivered [3]    = '{0, 0, 0};
  int last_del [3]     = '{0, 0, 0};
  int last_space [3]   = '{0, 0, 0};
  int edge_err [3]     = '{0, 0, 0};
  int code_err [3]     = '{0, 0, 0};
  int idle_hi_err [3]  = '{0, 0, 0};
  int mon_h;
  logic mon_s;
  logic [13:0] mon_e;

  always @(negedge clk) begin
    cycle++;
    for (int k = 0; k < 3; k++) begin
      mon_h = hb(k);
      if (act[k]) begin
        if (!act_p[k]) begin
          cyc[k] = 0; nhb[k] = 0; nbits[k] = 0; done[k] = 1'b0; wif[k] = 0;
          act_len[k] = 0; last_idle[k] = idle_len[k];
        end else begin
          cyc[k]++;
          if (ser[k] !== ser_p[k] && (cyc[k] % mon_h) != 0) edge_err[k]++;
        end
        act_len[k]++;
        if ((cyc[k] % mon_h) == mon_h / 2) begin
          mon_s = ser[k];
          if (nhb[k] < 16) begin
            hdr[k] = {hdr[k][14:0], mon_s};
            if (nhb[k] == 15) begin
              frames[k]++;
              tests_run++;
              if (hdr[k] !== HDR) begin
                tests_failed++;
                $display("FAIL header inst %0d: got %b want %b", k, hdr[k], HDR);
              end
            end
          end else if (!done[k]) begin
            if (((nhb[k] - 16) % 2) == 0) begin
              first[k] = mon_s;
            end else if (first[k] == mon_s) begin
              done[k] = 1'b1;
              if (mon_s) trailers[k]++;
              else       code_err[k]++;
            end else begin
              wbits[k] = {wbits[k][10:0], mon_s};
              nbits[k]++;
              if (nbits[k] == 12) begin
                nbits[k] = 0;
                wif[k]++;
                delivered[k]++;
                if (wif[k] > 1) last_space[k] = cycle - last_del[k];
                last_del[k] = cycle;
                tests_run++;
                if (exp_q.size() == 0) begin
                  tests_failed++;
                  $display("FAIL rx_word inst %0d: got %h, none expected", k, wbits[k]);
                end else begin
                  mon_e = exp_q.pop_front();
                  if (mon_e !== {k[1:0], wbits[k]}) begin
                    tests_failed++;
                    $display("FAIL rx_word inst %0d: got %h want inst %0d word %h",
                             k, wbits[k], mon_e[13:12], mon_e[11:0]);
                  end
                end
              end
            end
          end
          nhb[k]++;
        end
      end else begin
        if (act_p[k]) begin
          last_act_len[k] = act_len[k];
          last_fw[k] = wif[k];
          idle_len[k] = 0;
          if (!done[k]) aborts[k]++;
        end
        idle_len[k]++;
        if (ser[k]) idle_hi_err[k]++;
      end
    end
    act_p = act;
    ser_p = ser;
  end

  task automatic send(input int k, input logic [11:0] w);
    int n;
    n = 0;
    while (ready[k] !== 1'b1 && n < 4000) begin @(posedge clk); #1; n++; end
    tests_run++;
    if (n >= 4000) begin
      tests_failed++;
      $display("FAIL send_ready inst %0d: txReady still %b after %0d cycles", k, ready[k], n);
    end
    word[k]  = w;
    valid[k] = 1'b1;
    exp_q.push_back({k[1:0], w});
    @(posedge clk); #1;
    valid[k] = 1'b0;
  endtask

  task automatic burst(input int k, input logic [11:0] w0, input logic [11:0] w1, input logic [11:0] w2);
    logic [11:0] ws [3];
    ws[0] = w0; ws[1] = w1; ws[2] = w2;
    valid[k] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      int n;
      n = 0;
      while (ready[k] !== 1'b1 && n < 4000) begin @(posedge clk); #1; n++; end
      tests_run++;
      if (n >= 4000) begin
        tests_failed++;
        $display("FAIL burst_ready inst %0d word %0d: txReady still %b", k, i, ready[k]);
      end
      word[k] = ws[i];
      exp_q.push_back({k[1:0], ws[i]});
      @(posedge clk); #1;
    end
    valid[k] = 1'b0;
  endtask

  task automatic wait_quiet(input int k, input int target);
    int n;
    n = 0;
    while ((delivered[k] < target || act[k] !== 1'b0) && n < 8000) begin @(posedge clk); #1; n++; end
    tests_run++;
    if (n >= 8000) begin
      tests_failed++;
      $display("FAIL wait_quiet inst %0d: delivered %0d want %0d, txActive %b", k, delivered[k], target, act[k]);
    end
    repeat (8 * hb(k) + 4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      tests_run += 3;
      if (ready[k] !== 1'b0) begin tests_failed++; $display("FAIL reset_ready inst %0d: got %b want 0", k, ready[k]); end
      if (ser[k] !== 1'b0)   begin tests_failed++; $display("FAIL reset_serial inst %0d: got %b want 0", k, ser[k]); end
      if (act[k] !== 1'b0)   begin tests_failed++; $display("FAIL reset_active inst %0d: got %b want 0", k, act[k]); end
    end
    reset = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if (ready[k] !== 1'b1) begin tests_failed++; $display("FAIL release_ready inst %0d: got %b want 1", k, ready[k]); end
    end
  endtask

  task automatic test_single;
    int f0, t0, d0;
    f0 = frames[0]; t0 = trailers[0]; d0 = delivered[0];
    send(0, 12'h9C3);
    tests_run++;
    if (ready[0] !== 1'b0) begin tests_failed++; $display("FAIL single_ready_after_xfer: got %b want 0", ready[0]); end
    repeat (16 * 20 + 1) @(posedge clk);
    #1;
    tests_run++;
    if (ready[0] !== 1'b0) begin tests_failed++; $display("FAIL single_ready_at_load: got %b want 0", ready[0]); end
    @(posedge clk); #1;
    tests_run++;
    if (ready[0] !== 1'b1) begin tests_failed++; $display("FAIL single_ready_after_load: got %b want 1", ready[0]); end
    wait_quiet(0, d0 + 1);
    tests_run += 4;
    if (last_act_len[0] != 46 * 20) begin tests_failed++; $display("FAIL single_active_len: got %0d want %0d", last_act_len[0], 46 * 20); end
    if (last_fw[0] != 1)            begin tests_failed++; $display("FAIL single_words: got %0d want 1", last_fw[0]); end
    if (frames[0] != f0 + 1)        begin tests_failed++; $display("FAIL single_frames: got %0d want %0d", frames[0], f0 + 1); end
    if (trailers[0] != t0 + 1)      begin tests_failed++; $display("FAIL single_trailers: got %0d want %0d", trailers[0], t0 + 1); end
  endtask

  task automatic test_back_to_back;
    int f0, t0, d0;
    f0 = frames[0]; t0 = trailers[0]; d0 = delivered[0];
    burst(0, 12'h000, 12'hFFF, 12'h555);
    wait_quiet(0, d0 + 3);
    tests_run += 4;
    if (last_fw[0] != 3)       begin tests_failed++; $display("FAIL b2b_words: got %0d want 3", last_fw[0]); end
    if (last_space[0] != 480)  begin tests_failed++; $display("FAIL b2b_spacing: got %0d want 480", last_space[0]); end
    if (frames[0] != f0 + 1)   begin tests_failed++; $display("FAIL b2b_frames: got %0d want %0d", frames[0], f0 + 1); end
    if (trailers[0] != t0 + 1) begin tests_failed++; $display("FAIL b2b_trailers: got %0d want %0d", trailers[0], t0 + 1); end
  endtask

  // late = 0: second word lands on the word-boundary edge; late = 1: one cycle after it.
  task automatic second_word_at(input int late, input logic [11:0] w0, input logic [11:0] w1);
    send(0, w0);
    repeat (40 * 20 + late) @(posedge clk);
    #1;
    tests_run++;
    if (ready[0] !== 1'b1) begin tests_failed++; $display("FAIL second_word_ready late=%0d: got %b want 1", late, ready[0]); end
    word[0]  = w1;
    valid[0] = 1'b1;
    exp_q.push_back({2'd0, w1});
    @(posedge clk); #1;
    valid[0] = 1'b0;
  endtask

  task automatic test_boundary;
    int f0, t0, d0;
    f0 = frames[0]; t0 = trailers[0]; d0 = delivered[0];
    second_word_at(0, 12'hA5A, 12'h3C6);
    wait_quiet(0, d0 + 2);
    tests_run += 4;
    if (last_fw[0] != 2)       begin tests_failed++; $display("FAIL boundary_words: got %0d want 2", last_fw[0]); end
    if (last_space[0] != 480)  begin tests_failed++; $display("FAIL boundary_spacing: got %0d want 480", last_space[0]); end
    if (frames[0] != f0 + 1)   begin tests_failed++; $display("FAIL boundary_frames: got %0d want %0d", frames[0], f0 + 1); end
    if (trailers[0] != t0 + 1) begin tests_failed++; $display("FAIL boundary_trailers: got %0d want %0d", trailers[0], t0 + 1); end
  endtask

  task automatic test_underrun;
    int f0, t0, d0;
    f0 = frames[0]; t0 = trailers[0]; d0 = delivered[0];
    second_word_at(1, 12'h812, 12'h7ED);
    wait_quiet(0, d0 + 2);
    tests_run += 4;
    if (last_fw[0] != 1)       begin tests_failed++; $display("FAIL underrun_words: got %0d want 1", last_fw[0]); end
    if (frames[0] != f0 + 2)   begin tests_failed++; $display("FAIL underrun_frames: got %0d want %0d", frames[0], f0 + 2); end
    if (trailers[0] != t0 + 2) begin tests_failed++; $display("FAIL underrun_trailers: got %0d want %0d", trailers[0], t0 + 2); end
    if (last_idle[0] < 8 * 20) begin tests_failed++; $display("FAIL underrun_gap: got %0d want >= %0d", last_idle[0], 8 * 20); end
  endtask

  task automatic test_reset_mid;
    int d0, a0;
    logic [13:0] dropped;
    d0 = delivered[0]; a0 = aborts[0];
    send(0, 12'h7E1);
    repeat (26 * 20 + 5) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    tests_run += 3;
    if (ser[0] !== 1'b0)   begin tests_failed++; $display("FAIL midreset_serial: got %b want 0", ser[0]); end
    if (act[0] !== 1'b0)   begin tests_failed++; $display("FAIL midreset_active: got %b want 0", act[0]); end
    if (ready[0] !== 1'b0) begin tests_failed++; $display("FAIL midreset_ready: got %b want 0", ready[0]); end
    dropped = exp_q.pop_back();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    tests_run += 2;
    if (delivered[0] != d0)  begin tests_failed++; $display("FAIL midreset_no_word: delivered %0d want %0d (dropped %h)", delivered[0], d0, dropped[11:0]); end
    if (aborts[0] != a0 + 1) begin tests_failed++; $display("FAIL midreset_abort: got %0d want %0d", aborts[0], a0 + 1); end
    send(0, 12'h3C5);
    wait_quiet(0, d0 + 1);
    tests_run++;
    if (last_fw[0] != 1) begin tests_failed++; $display("FAIL midreset_recover: got %0d words want 1", last_fw[0]); end
  endtask

  task automatic test_edge_spacing;
    for (int k = 1; k < 3; k++) begin
      int f0, d0;
      f0 = frames[k]; d0 = delivered[k];
      burst(k, 12'($urandom), 12'($urandom), 12'($urandom));
      wait_quiet(k, d0 + 3);
      tests_run += 4;
      if (edge_err[k] != 0)          begin tests_failed++; $display("FAIL edges inst %0d: %0d off-grid edges want 0", k, edge_err[k]); end
      if (last_fw[k] != 3)           begin tests_failed++; $display("FAIL edge_words inst %0d: got %0d want 3", k, last_fw[k]); end
      if (last_space[k] != 24 * hb(k)) begin tests_failed++; $display("FAIL edge_spacing inst %0d: got %0d want %0d", k, last_space[k], 24 * hb(k)); end
      if (frames[k] != f0 + 1)       begin tests_failed++; $display("FAIL edge_frames inst %0d: got %0d want %0d", k, frames[k], f0 + 1); end
    end
  endtask

  task automatic test_line_health;
    for (int k = 0; k < 3; k++) begin
      tests_run += 3;
      if (edge_err[k] != 0)    begin tests_failed++; $display("FAIL health_edges inst %0d: got %0d want 0", k, edge_err[k]); end
      if (code_err[k] != 0)    begin tests_failed++; $display("FAIL health_code inst %0d: got %0d want 0", k, code_err[k]); end
      if (idle_hi_err[k] != 0) begin tests_failed++; $display("FAIL health_idle_low inst %0d: got %0d want 0", k, idle_hi_err[k]); end
    end
    tests_run++;
    if (exp_q.size() != 0) begin tests_failed++; $display("FAIL health_scoreboard: %0d words outstanding want 0", exp_q.size()); end
  endtask

  initial begin
    reset = 1'b1;
    valid = '0;
    for (int k = 0; k < 3; k++) word[k] = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_boundary();
    test_underrun();
    test_reset_mid();
    test_edge_spacing();
    test_line_health();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
